sha2_msg_sched: RTL

Parametrised SHA-2 message scheduler: accepts one 512/1024-bit padded block as 16 streamed words and emits the full expanded schedule W0..W(ROUNDS-1) on a valid/ready stream, one word per cycle when unstalled. It sits between the padding unit and the round/compression core. It generalises the fixed 32-bit, free-running scheduler with:
- SHA-512 support.
- Output backpressure.
- Explicit last-word marking.
- Synchronous abort.

---
 rtl/sha2_msg_sched.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sha2_msg_sched.sv
// SHA-2 message scheduler: loads 16 padded block words, then streams W0..W(ROUNDS-1).
// Latency: W0 is valid the cycle after the 16th accepted beat; one word per cycle while w_ready=1.
// Backpressure: w_ready=0 freezes window, round counter and outputs; blk_ready is low while emitting.
//
// Ports:
//   clk, rst        clock (rising edge); synchronous active-low reset
//   abort           synchronous flush of the block in progress (beat in that cycle is dropped)
//   blk_valid/ready/word   input word stream, W0 first
//   w_valid/ready/data     schedule word stream W_t
//   w_idx           round index t of w_data
//   w_last          marks t = ROUNDS-1
//   busy            words partially loaded, or schedule being emitted
module sha2_msg_sched #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [WORD_W-1:0] blk_word,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_data,
  output logic [6:0]        w_idx,
  output logic              w_last,
  output logic              busy
);

  localparam int          ROUNDS = (WORD_W == 32) ? 64 : 80;
  localparam logic [6:0]  LAST_T = 7'(ROUNDS - 1);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
    $error("sha2_msg_sched: WORD_W must be 32 or 64");
  end

  typedef enum logic {ST_LOAD, ST_EMIT} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win_d [16];
  logic [3:0]        ld_cnt_q, ld_cnt_d;
  logic [6:0]        t_q, t_d;

  logic              in_fire;
  logic              out_fire;
  logic [WORD_W-1:0] w_next;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    if (WORD_W == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    else              return rotr(x, 1) ^ rotr(x, 8)  ^ (x >> 7);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    if (WORD_W == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    else              return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  // Handshakes are qualified by state only, so blk_valid is ignored in EMIT
  // and w_ready is ignored in LOAD.
  assign in_fire  = (state_q == ST_LOAD) && blk_valid;
  assign out_fire = (state_q == ST_EMIT) && w_ready;

  // Window position k holds W(t+k): W(t+16) = s1(W(t+14)) + W(t+9) + s0(W(t+1)) + W(t).
  // Beyond t = ROUNDS-17 these words are never emitted; computing them anyway keeps the path uniform.
  assign w_next = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_LOAD;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------- next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (in_fire && ld_cnt_q == 4'd15) state_d = ST_EMIT;
      ST_EMIT: if (out_fire && t_q == LAST_T)    state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
    if (abort) state_d = ST_LOAD;
  end

  // ---------------------------------------------------------------- output decode
  always_comb begin
    blk_ready = (state_q == ST_LOAD);
    w_valid   = (state_q == ST_EMIT);
    w_last    = (state_q == ST_EMIT) && (t_q == LAST_T);
    busy      = (state_q == ST_EMIT) || (ld_cnt_q != 4'd0);
    w_data    = win_q[0];
    w_idx     = t_q;
  end

  // ---------------------------------------------------------------- datapath next state
  always_comb begin
    win_d    = win_q;
    ld_cnt_d = ld_cnt_q;
    t_d      = t_q;
    if (abort) begin
      // Window contents are left as-is; the next block overwrites all 16 entries.
      ld_cnt_d = 4'd0;
      t_d      = 7'd0;
    end else if (in_fire) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = blk_word;
      ld_cnt_d  = ld_cnt_q + 4'd1;   // wraps 15 -> 0 on the final beat
    end else if (out_fire) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = w_next;
      t_d       = (t_q == LAST_T) ? 7'd0 : t_q + 7'd1;
    end
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
      ld_cnt_q <= 4'd0;
      t_q      <= 7'd0;
    end else begin
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
      ld_cnt_q <= ld_cnt_d;
      t_q      <= t_d;
    end
  end

endmodule
